// File: rtl/serial_frame_deserializer.sv
// Receive side of the 16-to-1 serializer: rebuilds frames gated by frame_en into
// WIDTH-bit words and hands them to a consumer through a ready/ack handshake.
module serial_frame_deserializer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             frame_en,
    input  logic             serial_in,
    input  logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_ready,
    output logic             overrun,
    output logic             frame_error,
    output logic [WIDTH-1:0] shift_reg,
    output logic [CW-1:0]    bit_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECV   = 2'b01,
        DONE   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_d, data_d;
    logic [WIDTH-1:0]  shift_next, first_word;
    logic [CW-1:0]     count_d;
    logic              ready_d, overrun_d, error_d, complete;

    assign state = state_q;

    // The first bit of a frame starts from a cleared register so the display shows only this frame.
    assign shift_next = MSB_FIRST ? {shift_reg[WIDTH-2:0], serial_in}
                                  : {serial_in, shift_reg[WIDTH-1:1]};
    assign first_word = MSB_FIRST ? {{(WIDTH-1){1'b0}}, serial_in}
                                  : {serial_in, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            shift_reg   <= '0;
            bit_count   <= '0;
            data_out    <= '0;
            data_ready  <= 1'b0;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_reg   <= shift_d;
            bit_count   <= count_d;
            data_out    <= data_d;
            data_ready  <= ready_d;
            overrun     <= overrun_d;
            frame_error <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_reg;
        count_d   = bit_count;
        data_d    = data_out;
        ready_d   = data_ready;
        overrun_d = overrun;
        error_d   = 1'b0;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (frame_en) begin
                    shift_d = first_word;
                    count_d = CW'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                if (frame_en) begin
                    shift_d = shift_next;
                    if (bit_count == CW'(WIDTH - 1)) begin
                        complete = 1'b1;
                        data_d   = shift_next;
                        count_d  = '0;
                        state_d  = DONE;
                    end else begin
                        count_d = bit_count + CW'(1);
                    end
                end else begin
                    error_d = 1'b1;
                    shift_d = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (!frame_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An ack coinciding with a completed word consumes the old word, so no overrun.
        if (complete) begin
            ready_d   = 1'b1;
            overrun_d = ack ? 1'b0 : (overrun | data_ready);
        end else if (ack) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench: one MSB-first and one LSB-first instance fed the same word
// bit-orders so both should rebuild identical data_out values.
module tb_serial_frame_deserializer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_en = 1'b0;
    logic        serial_in = 1'b0;
    logic        serial_l = 1'b0;
    logic        ack = 1'b0;

    logic [15:0] data_out, shift_reg;
    logic        data_ready, overrun, frame_error;
    logic [4:0]  bit_count;
    logic [1:0]  state;

    logic [15:0] data_out_l, shift_reg_l;
    logic        data_ready_l, overrun_l, frame_error_l;
    logic [4:0]  bit_count_l;
    logic [1:0]  state_l;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    serial_frame_deserializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_msb (
        .clock(clock), .resetn(resetn), .frame_en(frame_en), .serial_in(serial_in), .ack(ack),
        .data_out(data_out), .data_ready(data_ready), .overrun(overrun),
        .frame_error(frame_error), .shift_reg(shift_reg), .bit_count(bit_count), .state(state)
    );

    serial_frame_deserializer #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
        .clock(clock), .resetn(resetn), .frame_en(frame_en), .serial_in(serial_l), .ack(ack),
        .data_out(data_out_l), .data_ready(data_ready_l), .overrun(overrun_l),
        .frame_error(frame_error_l), .shift_reg(shift_reg_l), .bit_count(bit_count_l), .state(state_l)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drives nbits of word with frame_en high; the MSB instance gets bit 15 first,
    // the LSB instance bit 0 first. ack is raised alongside the final bit if requested.
    task automatic applyStimulus(input logic [15:0] word, input int nbits, input bit ack_last);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            frame_en  = 1'b1;
            serial_in = word[15-i];
            serial_l  = word[i];
            ack       = (ack_last && i == nbits - 1);
        end
    endtask

    initial begin
        // Reset held with random activity on the inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            frame_en  = 1'($urandom_range(0, 1));
            serial_in = 1'($urandom_range(0, 1));
            serial_l  = 1'($urandom_range(0, 1));
        end
        checkOutput("rst_state", state, 0);
        checkOutput("rst_data", data_out, 0);
        checkOutput("rst_ready", data_ready, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_ferr", frame_error, 0);
        checkOutput("rst_shift", shift_reg, 0);
        checkOutput("rst_count", bit_count, 0);
        frame_en = 1'b0;
        resetn   = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("idle_after_rst", state, 0);

        // Basic frame
        applyStimulus(16'hA5C3, 16, 1'b0);
        @(negedge clock);
        checkOutput("basic_data", data_out, 16'hA5C3);
        checkOutput("lsb_data", data_out_l, 16'hA5C3);
        checkOutput("basic_ready", data_ready, 1);
        checkOutput("basic_state_done", state, 2);
        checkOutput("basic_count", bit_count, 0);
        frame_en = 1'b0;
        @(negedge clock);
        checkOutput("basic_state_idle", state, 0);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        checkOutput("basic_ack_ready", data_ready, 0);

        // Overrun: second word without an ack in between
        applyStimulus(16'h1234, 16, 1'b0);
        @(negedge clock);
        frame_en = 1'b0;
        applyStimulus(16'hBEEF, 16, 1'b0);
        @(negedge clock);
        checkOutput("ovr_data", data_out, 16'hBEEF);
        checkOutput("ovr_lsb_data", data_out_l, 16'hBEEF);
        checkOutput("ovr_ready", data_ready, 1);
        checkOutput("ovr_flag", overrun, 1);
        frame_en = 1'b0;
        ack      = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        checkOutput("ovr_ack_ready", data_ready, 0);
        checkOutput("ovr_ack_flag", overrun, 0);

        // Ack arriving on the completion edge of the next word
        applyStimulus(16'h1111, 16, 1'b0);
        @(negedge clock);
        frame_en = 1'b0;
        checkOutput("hold_1111", data_out, 16'h1111);
        applyStimulus(16'h2222, 16, 1'b1);
        @(negedge clock);
        ack = 1'b0;
        checkOutput("ackedge_data", data_out, 16'h2222);
        checkOutput("ackedge_ready", data_ready, 1);
        checkOutput("ackedge_overrun", overrun, 0);
        frame_en = 1'b0;
        ack      = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        checkOutput("ackedge_clear", data_ready, 0);

        // Short frame of 8 bits
        applyStimulus(16'h5A00, 8, 1'b0);
        @(negedge clock);
        checkOutput("short_count8", bit_count, 8);
        checkOutput("short_state", state, 1);
        frame_en = 1'b0;
        @(negedge clock);
        checkOutput("short_ferr", frame_error, 1);
        checkOutput("short_count0", bit_count, 0);
        checkOutput("short_shift", shift_reg, 0);
        checkOutput("short_state_idle", state, 0);
        checkOutput("short_data_kept", data_out, 16'h2222);
        @(negedge clock);
        checkOutput("short_ferr_pulse", frame_error, 0);

        // Reset mid-frame after five bits
        applyStimulus(16'hFFFF, 5, 1'b0);
        @(negedge clock);
        checkOutput("mid_count5", bit_count, 5);
        #2 resetn = 1'b0;
        #1;
        checkOutput("mid_rst_count", bit_count, 0);
        checkOutput("mid_rst_shift", shift_reg, 0);
        checkOutput("mid_rst_state", state, 0);
        checkOutput("mid_rst_data", data_out, 0);
        @(negedge clock);
        frame_en = 1'b0;
        resetn   = 1'b1;
        applyStimulus(16'h0F0F, 16, 1'b0);
        @(negedge clock);
        checkOutput("post_rst_data", data_out, 16'h0F0F);
        checkOutput("post_rst_lsb", data_out_l, 16'h0F0F);
        checkOutput("post_rst_ready", data_ready, 1);
        frame_en = 1'b0;
        ack      = 1'b1;
        @(negedge clock);
        ack = 1'b0;

        // frame_en held high for 20 cycles
        applyStimulus(16'h9C3A, 16, 1'b0);
        @(negedge clock);
        checkOutput("long_state16", state, 2);
        checkOutput("long_data16", data_out, 16'h9C3A);
        for (int i = 0; i < 4; i++) begin
            serial_in = ~serial_in;
            serial_l  = ~serial_l;
            @(negedge clock);
            checkOutput($sformatf("long_hold_state%0d", i), state, 2);
        end
        frame_en = 1'b0;
        @(negedge clock);
        checkOutput("long_state_idle", state, 0);
        checkOutput("long_data", data_out, 16'h9C3A);
        checkOutput("long_lsb_data", data_out_l, 16'h9C3A);
        checkOutput("long_overrun", overrun, 0);
        checkOutput("long_ready", data_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
